io_port_responder: RTL and testbench
====================================

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized samples needed to commit an input value (legal range 2..255).
REQ-002 The block SHALL have port mem_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port addr, input, 32, byte address from the memory stage ALU result.
REQ-005 The block SHALL have port wdata, input, 32, store data.
REQ-006 The block SHALL have port we, input, 1, store strobe, sampled at the rising edge of mem_clock.
REQ-007 The block SHALL have port rd_data, output, 32, combinational read data for addr.
REQ-008 The block SHALL have ports in_port0 and in_port1, input, 32 each, asynchronous external inputs (switches/keys).
REQ-009 The block SHALL have ports out_port0, out_port1 and out_port2, output, 32 each, registered external outputs (LED/segment drivers).

Function
REQ-010 The block SHALL treat an access as I/O only when addr[7]=1; for addr[7]=0, rd_data SHALL be 0 and writes SHALL have no effect.
REQ-011 The block SHALL decode on addr[7:2] only, with addr[1:0] and addr[31:8] ignored: 0x80 out0 (RW), 0x84 out1 (RW), 0x88 out2 (RW), 0xC0 in0 (RO), 0xC4 in1 (RO), 0xC8 status (R, W1C).
REQ-012 When we=1 and addr selects out0, out1 or out2, the block SHALL load wdata into that register at the same edge, and the new value SHALL be visible on out_portN and rd_data after that edge.
REQ-013 Writes to 0xC0, 0xC4 or to an undecoded I/O offset SHALL be ignored; reads of an undecoded I/O offset SHALL return 0.
REQ-014 Each in_port SHALL pass through a two-flop synchronizer, 32 bits wide, before any other use.
REQ-015 Debounce for each port, acting on the whole word: if the synchronized value differs from the candidate, then candidate <= synchronized value and count <= 0; else if count < DEBOUNCE_CYCLES-1, then count increments; else if stable differs from candidate, then stable <= candidate and the change flag is set.
REQ-016 A single step change on in_portN held steady SHALL appear in the stable value, and on rd_data at 0xC0/0xC4, after rising edge DEBOUNCE_CYCLES+3 counted from the first edge after the change (edge 7 for the default).
REQ-017 A glitch that lasts fewer synchronized cycles than DEBOUNCE_CYCLES SHALL never reach the stable value or set a flag.
REQ-018 Status bit0 SHALL be the sticky change flag for in0 and bit1 the sticky change flag for in1; bits 31:2 SHALL read 0.
REQ-019 A write to 0xC8 SHALL clear each flag whose wdata bit is 1 and leave the other flags unchanged.
REQ-020 If a flag set event and its W1C occur at the same edge, the set SHALL win and the flag SHALL remain 1.
REQ-021 The counter SHALL saturate at DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 rd_data SHALL be a purely combinational function of addr and the register state, with zero cycles of latency.

Reset
REQ-023 While resetn=0, out_port0, out_port1, out_port2, the synchronizers, the candidates, the stable values, the counters and the status register SHALL be 0, independent of mem_clock.
REQ-024 Deassertion of reset mid-debounce SHALL restart debouncing from the zero state, and no flag SHALL be set for a change that was pending before reset.
REQ-025 After reset, a nonzero input SHALL be treated as a change from 0 and SHALL set its flag once it is committed.

Verification
REQ-026 Write test: we=1, addr=0x84, wdata=0xDEADBEEF for one edge -> out_port1=0xDEADBEEF; out_port0 and out_port2 stay 0; read 0x84 returns 0xDEADBEEF; addr=0x04 with we=1 changes nothing.
REQ-027 Debounce timing: in_port0 steps 0 to 0x0000_00A5 before edge 1 -> read 0xC0 returns 0 through edge 6 and 0xA5 after edge 7; status reads 0x1.
REQ-028 Glitch rejection: in_port1 pulses 0x1 for 3 cycles and then returns to 0 -> read 0xC4 stays 0 and status bit1 stays 0.
REQ-029 W1C collision: status=0x1 and a W1C of 0x3 lands on the same edge that in1 commits -> status=0x2 after that edge; a following W1C of 0x2 -> status=0.
REQ-030 Reset mid-operation: out_port2=0x55 with in0 mid-debounce, then resetn pulsed low asynchronously between edges -> all outputs 0 immediately; after release in0=0xA5 commits on edge 7 with status=0x1.

Source files
------------

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder
// Description : Memory-mapped I/O responder. Three read/write output
//               registers, two debounced input ports and a sticky
//               change-status register with write-one-to-clear.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_responder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        mem_clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rd_data,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2
);

    // Word offsets within the I/O window (addr[6:2], with addr[7] = 1)
    localparam logic [4:0] c_off_out0   = 5'b00000;   // 0x80
    localparam logic [4:0] c_off_out1   = 5'b00001;   // 0x84
    localparam logic [4:0] c_off_out2   = 5'b00010;   // 0x88
    localparam logic [4:0] c_off_in0    = 5'b10000;   // 0xC0
    localparam logic [4:0] c_off_in1    = 5'b10001;   // 0xC4
    localparam logic [4:0] c_off_status = 5'b10010;   // 0xC8

    // Counter saturation value; DEBOUNCE_CYCLES never exceeds 255
    localparam logic [7:0] c_cnt_max = 8'(DEBOUNCE_CYCLES - 1);

    logic        w_io;
    logic [4:0]  w_sel;
    logic        w_wr;
    logic [1:0]  w_clr;
    logic [1:0]  w_commit;
    logic [1:0][31:0] w_in;
    logic [1:0][31:0] w_stable;

    logic [31:0] r_out0;
    logic [31:0] r_out1;
    logic [31:0] r_out2;
    logic [1:0]  r_status;

    assign w_io   = addr[7];
    assign w_sel  = addr[6:2];
    assign w_wr   = we & w_io;
    assign w_clr  = (w_wr && (w_sel == c_off_status)) ? wdata[1:0] : 2'b00;
    assign w_in[0] = in_port0;
    assign w_in[1] = in_port1;

    // Per-port synchronizer and whole-word debouncer
    for (genvar i = 0; i < 2; i++) begin : g_port
        logic [31:0] r_sync1;
        logic [31:0] r_sync2;
        logic [31:0] r_cand;
        logic [31:0] r_stable;
        logic [7:0]  r_cnt;

        // Two-flop synchronizer followed by candidate/count/stable update
        always_ff @(posedge mem_clock or negedge resetn) begin
            if (!resetn) begin
                r_sync1  <= '0;
                r_sync2  <= '0;
                r_cand   <= '0;
                r_stable <= '0;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_in[i];
                r_sync2 <= r_sync1;
                if (r_sync2 != r_cand) begin
                    r_cand <= r_sync2;
                    r_cnt  <= '0;
                end else if (r_cnt < c_cnt_max) begin
                    r_cnt <= r_cnt + 8'd1;
                end else if (r_stable != r_cand) begin
                    r_stable <= r_cand;
                end
            end
        end

        // A commit happens on exactly the edge the stable value is loaded
        assign w_commit[i] = (r_sync2 == r_cand) && (r_cnt >= c_cnt_max) &&
                             (r_stable != r_cand);
        assign w_stable[i] = r_stable;
    end

    // Output registers and sticky status; a same-edge set beats the clear
    always_ff @(posedge mem_clock or negedge resetn) begin
        if (!resetn) begin
            r_out0   <= '0;
            r_out1   <= '0;
            r_out2   <= '0;
            r_status <= '0;
        end else begin
            if (w_wr && (w_sel == c_off_out0)) r_out0 <= wdata;
            if (w_wr && (w_sel == c_off_out1)) r_out1 <= wdata;
            if (w_wr && (w_sel == c_off_out2)) r_out2 <= wdata;
            r_status <= (r_status & ~w_clr) | w_commit;
        end
    end

    assign out_port0 = r_out0;
    assign out_port1 = r_out1;
    assign out_port2 = r_out2;

    // Zero-latency read mux; anything outside the decoded window reads 0
    always_comb begin
        rd_data = '0;
        if (w_io) begin
            case (w_sel)
                c_off_out0:   rd_data = r_out0;
                c_off_out1:   rd_data = r_out1;
                c_off_out2:   rd_data = r_out2;
                c_off_in0:    rd_data = w_stable[0];
                c_off_in1:    rd_data = w_stable[1];
                c_off_status: rd_data = {30'b0, r_status};
                default:      rd_data = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_responder
// Description : Directed self-checking bench for io_port_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_responder;

    logic        mem_clock;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd_data;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;

    int tests_run    = 0;
    int tests_failed = 0;

    io_port_responder #(.DEBOUNCE_CYCLES(4)) dut (
        .mem_clock (mem_clock),
        .resetn    (resetn),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rd_data   (rd_data),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2)
    );

    initial mem_clock = 1'b0;
    always #5 mem_clock = ~mem_clock;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge mem_clock);
        #1;
    endtask

    // Present a read address and let the combinational mux settle
    task automatic set_addr(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        in_port0 = '0; in_port1 = '0;
        #12;
        tests_run++;
        if ({out_port0, out_port1, out_port2} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_outs: got %h %h %h expected 0", out_port0, out_port1, out_port2);
        end
        set_addr(32'hC8);
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 0", rd_data);
        end
        @(negedge mem_clock);
        resetn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_write();
        we = 1'b1; addr = 32'h84; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        tests_run++;
        if (out_port1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_out1: got %h expected deadbeef", out_port1);
        end
        tests_run++;
        if (out_port0 !== 32'h0 || out_port2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_others: got %h %h expected 0 0", out_port0, out_port2);
        end
        set_addr(32'h84);
        tests_run++;
        if (rd_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL read_out1: got %h expected deadbeef", rd_data);
        end
        // Non-I/O address must not write anything and reads as 0
        we = 1'b1; addr = 32'h04; wdata = 32'h12345678;
        tick();
        we = 1'b0;
        tests_run++;
        if (out_port0 !== 32'h0 || out_port1 !== 32'hDEADBEEF || out_port2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_nonio: got %h %h %h expected 0 deadbeef 0", out_port0, out_port1, out_port2);
        end
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_nonio: got %h expected 0", rd_data);
        end
        // Upper and low address bits are ignored: 0xFFFFFF83 aliases 0x80
        we = 1'b1; addr = 32'hFFFF_FF83; wdata = 32'h11223344;
        tick();
        we = 1'b0;
        tests_run++;
        if (out_port0 !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL write_alias_out0: got %h expected 11223344", out_port0);
        end
        set_addr(32'h0000_0180);
        tests_run++;
        if (rd_data !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL read_alias_out0: got %h expected 11223344", rd_data);
        end
        // Undecoded I/O offset: write ignored, reads 0
        we = 1'b1; addr = 32'h9C; wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        tests_run++;
        if (out_port0 !== 32'h11223344 || out_port1 !== 32'hDEADBEEF || out_port2 !== 32'h0 || rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL undecoded: got %h %h %h rd %h expected 11223344 deadbeef 0 rd 0",
                     out_port0, out_port1, out_port2, rd_data);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] exp;
        set_addr(32'hC0);
        in_port0 = 32'h0000_00A5;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp = (e >= 7) ? 32'hA5 : 32'h0;
            tests_run++;
            if (rd_data !== exp) begin
                tests_failed++;
                $display("FAIL debounce_edge%0d: got %h expected %h", e, rd_data, exp);
            end
        end
        set_addr(32'hC8);
        tests_run++;
        if (rd_data !== 32'h1) begin
            tests_failed++;
            $display("FAIL debounce_status: got %h expected 1", rd_data);
        end
        // Writes to the input port address are ignored
        we = 1'b1; addr = 32'hC0; wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        tests_run++;
        if (rd_data !== 32'hA5) begin
            tests_failed++;
            $display("FAIL write_in0_ignored: got %h expected a5", rd_data);
        end
    endtask

    task automatic test_glitch();
        in_port1 = 32'h1;
        repeat (3) tick();
        in_port1 = 32'h0;
        repeat (10) tick();
        set_addr(32'hC4);
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL glitch_in1: got %h expected 0", rd_data);
        end
        set_addr(32'hC8);
        tests_run++;
        if (rd_data !== 32'h1) begin
            tests_failed++;
            $display("FAIL glitch_status: got %h expected 1", rd_data);
        end
    endtask

    task automatic test_w1c_collision();
        in_port1 = 32'h7;
        repeat (6) tick();
        set_addr(32'hC8);
        tests_run++;
        if (rd_data !== 32'h1) begin
            tests_failed++;
            $display("FAIL collision_pre: got %h expected 1", rd_data);
        end
        we = 1'b1; wdata = 32'h3;
        tick();                 // edge 7: in1 commits while W1C of 0x3 lands
        we = 1'b0;
        tests_run++;
        if (rd_data !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_status: got %h expected 2", rd_data);
        end
        set_addr(32'hC4);
        tests_run++;
        if (rd_data !== 32'h7) begin
            tests_failed++;
            $display("FAIL collision_in1: got %h expected 7", rd_data);
        end
        we = 1'b1; addr = 32'hC8; wdata = 32'h2;
        tick();
        we = 1'b0;
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL w1c_clear: got %h expected 0", rd_data);
        end
        // With inputs steady no new flag may appear
        repeat (20) tick();
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL steady_status: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        we = 1'b1; addr = 32'h88; wdata = 32'h55;
        tick();
        we = 1'b0;
        tests_run++;
        if (out_port2 !== 32'h55) begin
            tests_failed++;
            $display("FAIL out2_write: got %h expected 55", out_port2);
        end
        in_port0 = 32'h3C;
        repeat (3) tick();
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if ({out_port0, out_port1, out_port2} !== 96'h0) begin
            tests_failed++;
            $display("FAIL async_reset_outs: got %h %h %h expected 0", out_port0, out_port1, out_port2);
        end
        set_addr(32'hC0);
        tests_run++;
        if (rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset_in0: got %h expected 0", rd_data);
        end
        in_port0 = 32'hA5;
        in_port1 = 32'h0;
        @(posedge mem_clock);
        @(posedge mem_clock);
        @(negedge mem_clock);
        resetn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            set_addr(32'hC0);
            exp = (e >= 7) ? 32'hA5 : 32'h0;
            tests_run++;
            if (rd_data !== exp) begin
                tests_failed++;
                $display("FAIL post_reset_in0_edge%0d: got %h expected %h", e, rd_data, exp);
            end
            set_addr(32'hC8);
            exp = (e >= 7) ? 32'h1 : 32'h0;
            tests_run++;
            if (rd_data !== exp) begin
                tests_failed++;
                $display("FAIL post_reset_status_edge%0d: got %h expected %h", e, rd_data, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_debounce();
        test_glitch();
        test_w1c_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
